ibus_responder: RTL
===================

Name: ibus_responder

Overview:
- Instruction-bus slave: the responder end of the ibus_req_t / ibus_resp_t handshake that fetch/decode consume.
- Accepts fetch requests, returns instruction words from an internal preloadable word array after a fixed latency.
- Responses are in order, with a bounded number of requests outstanding.
- Used as the simulation instruction memory behind the CPU core and as the golden responder for ibus protocol tests.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from request acceptance to data_ok; must be >= 1.
- MAX_OUT, 2, maximum accepted-but-unanswered requests; 1 <= MAX_OUT <= LATENCY.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ireq  input  ibus_req_t  request; fields valid (1) and addr (32).
- iresp  output  ibus_resp_t  response; fields addr_ok (1), data_ok (1) and data (32).
- stall  input  1  external throttle; when 1, new requests are refused.
- pl_en  input  1  preload write enable.
- pl_idx  input  $clog2(DEPTH)  preload word index.
- pl_data  input  32  preload write data.
- busy  output  1  high while any request is outstanding.

Behaviour:
- Reset (async, while reset=1):
  - outstanding count = 0, all pipeline stage valids = 0.
  - iresp.data_ok = 0, iresp.data = 0, busy = 0.
  - Array contents are not cleared.
  - Requests in flight when reset asserts are discarded; no data_ok for them after reset releases.
- addr_ok:
  - Combinational: addr_ok = !reset && !stall && (count < MAX_OUT || retire).
  - retire = the last pipeline stage is valid this cycle.
  - addr_ok must not depend on ireq.valid.
- Acceptance:
  - A request is accepted in cycle T iff ireq.valid && iresp.addr_ok at the rising edge ending T.
  - At most one acceptance per cycle.
  - Word index = ireq.addr[$clog2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4. addr[1:0] are ignored.
  - The array is read at acceptance. Word and valid enter a LATENCY-deep shift pipeline.
- Response:
  - iresp.data_ok = 1 for exactly one cycle, in cycle T+LATENCY.
  - iresp.data holds the captured word in that cycle; data holds its last value otherwise.
  - The responder has no backpressure: the requester must take data in the data_ok cycle.
  - Order equals acceptance order.
- Count:
  - +1 on accept, -1 on retire. Accept and retire in the same cycle leaves count unchanged.
  - Count never exceeds MAX_OUT and never underflows.
  - busy = (count != 0).
- Throughput: with MAX_OUT == LATENCY and stall=0, one request is accepted and one answered every cycle in steady state.
- Preload:
  - pl_en writes pl_data to array[pl_idx] at the edge.
  - Write and accept to the same word in one cycle: the accepted request captures the OLD word.
  - Preload has no effect on requests already in flight.
- The stall input does not affect requests already accepted; their data_ok still arrives on schedule.
- ireq.addr is don't-care when valid=0. A valid that drops before acceptance is legal and is simply not accepted.

Test Plan:
- Reset/idle: hold reset 3 cycles, release with ireq.valid=0 -> data_ok=0, data=0, busy=0, addr_ok=1 for 5 cycles.
- Single fetch: preload array[1]=0x2408000A, request addr 0xBFC00004 at T -> addr_ok=1 at T; data_ok=1 with data=0x2408000A at T+2 only.
- Back-to-back (LATENCY=2, MAX_OUT=2): preload words 0..3 = 0x11,0x22,0x33,0x44; valid with addr 0x0,0x4,0x8,0xC over 4 consecutive cycles -> all accepted; data_ok in 4 consecutive cycles carrying 0x11,0x22,0x33,0x44 in order.
- Full/throttle (MAX_OUT=1, LATENCY=3): continuous valid -> accepts only every 3rd cycle, addr_ok=0 in the 2 cycles between; stall=1 for 4 cycles -> no accepts, while the in-flight data_ok still occurs.
- Hazard + wrap: DEPTH=256, same-cycle pl_en writes array[0]=0xDEAD while request addr 0x400 is accepted (index 0) -> response returns the old value 0x11; next request to 0x0 returns 0xDEAD.
- Reset mid-flight: accept 2 requests, assert reset one cycle before the first data_ok -> no data_ok in the 6 cycles after release, count=0, busy=0.

Source files
------------

// File: rtl/ibus_responder.sv
// Instruction-bus responder: fixed-latency word fetch from a preloadable array.
// Latency: data_ok exactly LATENCY cycles after the accepting edge; responses in order.
// Backpressure: addr_ok drops on stall or when MAX_OUT requests are outstanding; no response backpressure.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   ireq_valid, ireq_addr           fetch request (byte address, word aligned)
//   iresp_addr_ok                   request accepted this cycle if ireq_valid is also high
//   iresp_data_ok, iresp_data       one-cycle response strobe and held instruction word
//   stall                           refuses new requests while high
//   pl_en, pl_idx, pl_data          preload write port into the word array
//   busy                            high while any request is outstanding
module ibus_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ireq_valid,
    input  logic [31:0]              ireq_addr,
    output logic                     iresp_addr_ok,
    output logic                     iresp_data_ok,
    output logic [31:0]              iresp_data,
    input  logic                     stall,
    input  logic                     pl_en,
    input  logic [$clog2(DEPTH)-1:0] pl_idx,
    input  logic [31:0]              pl_data,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);

    // Word array; deliberately not reset so preloaded contents survive a reset.
    logic [31:0] mem_q [DEPTH];

    logic [CW-1:0]      count_q, count_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [31:0]        dat_q [LATENCY];
    logic [31:0]        dat_d [LATENCY];

    // Inputs to each pipeline stage: stage 0 is fed by the array read at acceptance.
    logic [LATENCY-1:0] vld_in;
    logic [31:0]        dat_in [LATENCY];

    logic          accept;
    logic          retire;
    logic [AW-1:0] rd_idx;
    logic          unused_addr;

    // Byte offset and address bits above the array size are ignored, so fetches wrap.
    assign rd_idx      = ireq_addr[AW+1:2];
    assign unused_addr = ^{ireq_addr[31:AW+2], ireq_addr[1:0]};

    assign retire        = vld_q[LATENCY-1];
    assign iresp_addr_ok = !reset && !stall && ((count_q < CW'(MAX_OUT)) || retire);
    assign accept        = ireq_valid && iresp_addr_ok;

    assign iresp_data_ok = vld_q[LATENCY-1];
    assign iresp_data    = dat_q[LATENCY-1];
    assign busy          = (count_q != '0);

    assign vld_in[0] = accept;
    assign dat_in[0] = mem_q[rd_idx];

    genvar k;
    generate
        for (k = 1; k < LATENCY; k++) begin : g_chain
            assign vld_in[k] = vld_q[k-1];
            assign dat_in[k] = dat_q[k-1];
        end
    endgenerate

    always_comb begin
        vld_d = vld_in;
        for (int i = 0; i < LATENCY; i++) begin
            dat_d[i] = dat_in[i];
        end
        // The output stage only loads on a real response so iresp_data holds between responses.
        if (!vld_in[LATENCY-1]) begin
            dat_d[LATENCY-1] = dat_q[LATENCY-1];
        end
        // Accept and retire in the same cycle cancel out.
        count_d = count_q + CW'(accept) - CW'(retire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            vld_q   <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Array write lands at the same edge as an accept; the accepted request
    // captured the pre-write word through dat_in[0].
    always_ff @(posedge clk) begin
        if (pl_en) begin
            mem_q[pl_idx] <= pl_data;
        end
    end

endmodule
